// File: rtl/uart_tx_arb_if.sv
// Handshake bundle between the requesters, the arbiter and the UART TX FIFO write path.
// master drives requester bytes and the FIFO ready; slave is the arbiter.
interface uart_tx_arb_if #(
    parameter int NumReq = 4
);
    logic [NumReq-1:0]   req_valid_i;
    logic [NumReq*8-1:0] req_data_i;
    logic [NumReq-1:0]   req_last_i;
    logic [NumReq-1:0]   req_ready_o;
    logic                tx_valid_o;
    logic [7:0]          tx_data_o;
    logic                tx_ready_i;
    logic [NumReq-1:0]   grant_o;
    logic                busy_o;
    logic                timeout_o;

    modport master (
        output req_valid_i, req_data_i, req_last_i, tx_ready_i,
        input  req_ready_o, tx_valid_o, tx_data_o, grant_o, busy_o, timeout_o
    );

    modport slave (
        input  req_valid_i, req_data_i, req_last_i, tx_ready_i,
        output req_ready_o, tx_valid_o, tx_data_o, grant_o, busy_o, timeout_o
    );
endinterface

// File: rtl/uart_tx_arb.sv
// Packet-granular round-robin arbiter feeding one UART TX byte stream; a lock is held
// until the owner's last byte, or reclaimed after TimeoutCycles idle cycles.
module uart_tx_arb #(
    parameter int NumReq        = 4,
    parameter int TimeoutCycles = 1024,
    parameter int CntW          = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    uart_tx_arb_if.slave bus
);
    localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam logic [CntW-1:0] TimeoutLim = CntW'(TimeoutCycles);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t              state;
    logic [IdxW-1:0]     owner;
    logic [IdxW-1:0]     rr_ptr;
    logic [CntW-1:0]     cnt;
    logic                tx_valid_q;
    logic [7:0]          tx_data_q;
    logic [NumReq-1:0]   grant_q;
    logic                busy_q;
    logic                timeout_q;

    logic                slot_free;
    logic                beat;
    logic                owner_valid;
    logic                expire;
    logic [IdxW-1:0]     sel;
    logic                sel_found;
    logic [IdxW-1:0]     next_ptr;
    logic [NumReq-1:0]   ready;
    logic [7:0]          owner_data;

    assign slot_free   = !tx_valid_q || bus.tx_ready_i;
    assign owner_valid = bus.req_valid_i[owner];
    assign owner_data  = bus.req_data_i[{owner, 3'b000} +: 8];
    assign beat        = (state == LOCKED) && owner_valid && slot_free;
    assign expire      = (TimeoutCycles != 0) && !owner_valid && (cnt + CntW'(1) == TimeoutLim);
    assign next_ptr    = (owner == IdxW'(NumReq - 1)) ? '0 : owner + 1'b1;

    // First valid requester at or above rr_ptr, wrapping around.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        sel       = '0;
        sel_found = 1'b0;
        for (int k = 0; k < NumReq; k++) begin
            idx = (int'(rr_ptr) + k) % NumReq;
            if (!sel_found && bus.req_valid_i[idx]) begin
                sel       = IdxW'(idx);
                sel_found = 1'b1;
            end
        end
    end

    always_comb begin
        ready = '0;
        if (state == LOCKED) ready[owner] = slot_free;
    end

    assign bus.req_ready_o = ready;
    assign bus.tx_valid_o  = tx_valid_q;
    assign bus.tx_data_o   = tx_data_q;
    assign bus.grant_o     = grant_q;
    assign bus.busy_o      = busy_q;
    assign bus.timeout_o   = timeout_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            owner      <= '0;
            rr_ptr     <= '0;
            cnt        <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            grant_q    <= '0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            timeout_q <= 1'b0;

            // Output slot: load on a beat, otherwise drain when the FIFO accepts.
            if (beat) begin
                tx_valid_q <= 1'b1;
                tx_data_q  <= owner_data;
            end else if (bus.tx_ready_i) begin
                tx_valid_q <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (sel_found) begin
                        state   <= LOCKED;
                        owner   <= sel;
                        grant_q <= NumReq'(1) << sel;
                        busy_q  <= 1'b1;
                        cnt     <= '0;
                    end
                end
                LOCKED: begin
                    if (beat) begin
                        cnt <= '0;
                        if (bus.req_last_i[owner]) begin
                            state   <= IDLE;
                            grant_q <= '0;
                            busy_q  <= 1'b0;
                            rr_ptr  <= next_ptr;
                        end
                    end else if (!owner_valid) begin
                        // Only a silent owner counts; back-pressure never does.
                        if (expire) begin
                            state     <= IDLE;
                            grant_q   <= '0;
                            busy_q    <= 1'b0;
                            timeout_q <= 1'b1;
                            rr_ptr    <= next_ptr;
                            cnt       <= '0;
                        end else begin
                            cnt <= cnt + CntW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: two instances (timeout 4 and 8) share one stimulus
// stream; a small requester model feeds bytes and advances on accepted beats.
module tb_uart_tx_arb;
    localparam int N = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_arb_if #(.NumReq(N)) b4 ();
    uart_tx_arb_if #(.NumReq(N)) b8 ();

    assign b8.req_valid_i = b4.req_valid_i;
    assign b8.req_data_i  = b4.req_data_i;
    assign b8.req_last_i  = b4.req_last_i;
    assign b8.tx_ready_i  = b4.tx_ready_i;

    uart_tx_arb #(.NumReq(N), .TimeoutCycles(4), .CntW(16)) dut4 (
        .clk_i(clk), .rst_ni(rst_n), .bus(b4.slave)
    );
    uart_tx_arb #(.NumReq(N), .TimeoutCycles(8), .CntW(16)) dut8 (
        .clk_i(clk), .rst_ni(rst_n), .bus(b8.slave)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  mb [N][4];
    int          mlen [N];
    int          mpos [N];
    bit          mwl [N];
    bit          use8 = 1'b0;
    bit          to4_seen = 1'b0;
    logic [N-1:0] gprev = '0;
    logic [7:0]  q4 [$];
    logic [N-1:0] gq [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        logic [N-1:0]   v;
        logic [N-1:0]   l;
        logic [N*8-1:0] d;
        v = '0; l = '0; d = '0;
        for (int i = 0; i < N; i++) begin
            if (mpos[i] < mlen[i]) begin
                v[i]         = 1'b1;
                d[i*8 +: 8]  = mb[i][mpos[i]];
                l[i]         = mwl[i] && (mpos[i] == mlen[i] - 1);
            end
        end
        b4.req_valid_i = v;
        b4.req_data_i  = d;
        b4.req_last_i  = l;
    endtask

    task automatic load(input int i, input int len, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [7:0] e, input bit wl);
        mb[i][0] = a; mb[i][1] = b; mb[i][2] = c; mb[i][3] = e;
        mlen[i] = len; mpos[i] = 0; mwl[i] = wl;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N; i++) begin
            mlen[i] = 0; mpos[i] = 0; mwl[i] = 1'b0;
        end
        drive();
    endtask

    // One clock: sample handshakes at the falling edge, advance the model after the rise.
    task automatic tick();
        logic [N-1:0] bm;
        @(negedge clk);
        bm = use8 ? (b8.req_ready_o & b8.req_valid_i) : (b4.req_ready_o & b4.req_valid_i);
        if (b4.tx_valid_o && b4.tx_ready_i) q4.push_back(b4.tx_data_o);
        if (b4.timeout_o) to4_seen = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (bm[i]) mpos[i]++;
        drive();
        if (b4.grant_o != '0 && b4.grant_o != gprev) gq.push_back(b4.grant_o);
        gprev = b4.grant_o;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_reqs();
        tick();
        tick();
        rst_n = 1'b1;
        gprev = '0;
    endtask

    task automatic run_until_idle(input int max_cycles);
        bit done;
        int n;
        n = 0;
        done = 1'b0;
        while (!done && n < max_cycles) begin
            tick();
            n++;
            done = 1'b1;
            for (int i = 0; i < N; i++) if (mpos[i] < mlen[i]) done = 1'b0;
            if (use8 ? (b8.tx_valid_o || b8.busy_o) : (b4.tx_valid_o || b4.busy_o)) done = 1'b0;
        end
        check("drain_within_budget", done, 1);
    endtask

    task automatic check_zero_outputs();
        check("rst_tx_valid", b4.tx_valid_o, 0);
        check("rst_tx_data", b4.tx_data_o, 0);
        check("rst_grant", b4.grant_o, 0);
        check("rst_busy", b4.busy_o, 0);
        check("rst_timeout", b4.timeout_o, 0);
        check("rst_req_ready", b4.req_ready_o, 0);
    endtask

    initial begin
        b4.tx_ready_i = 1'b1;
        clear_reqs();
        #12;
        check_zero_outputs();
        check("rst_rr_ptr", dut4.rr_ptr, 0);

        // Single message from req0
        do_reset();
        load(0, 3, 8'hA5, 8'h5A, 8'hFF, 8'h00, 1'b1);
        drive();
        tick();
        check("single_grant", b4.grant_o, 4'b0001);
        check("single_busy", b4.busy_o, 1);
        tick();
        check("single_valid0", b4.tx_valid_o, 1);
        check("single_byte0", b4.tx_data_o, 8'hA5);
        tick();
        check("single_byte1", b4.tx_data_o, 8'h5A);
        tick();
        check("single_byte2", b4.tx_data_o, 8'hFF);
        check("single_busy_drop", b4.busy_o, 0);
        check("single_grant_drop", b4.grant_o, 0);
        check("single_rr_ptr", dut4.rr_ptr, 1);

        // Round-robin fairness, run twice
        do_reset();
        for (int rep = 0; rep < 2; rep++) begin
            q4.delete();
            gq.delete();
            for (int i = 0; i < N; i++) load(i, 2, 8'h10 + 8'(i), 8'h20 + 8'(i), 8'h00, 8'h00, 1'b1);
            drive();
            run_until_idle(60);
            check("rr_grant_count", gq.size(), 4);
            for (int k = 0; k < 4 && k < gq.size(); k++) check("rr_grant_order", gq[k], 4'b0001 << k);
            check("rr_byte_count", q4.size(), 8);
            for (int k = 0; k < 4 && 2 * k + 1 < q4.size(); k++) begin
                check("rr_stream_first", q4[2*k], 8'h10 + 8'(k));
                check("rr_stream_last", q4[2*k+1], 8'h20 + 8'(k));
            end
        end

        // Back-pressure on req1 with a 4-cycle timeout that must not fire
        q4.delete();
        to4_seen = 1'b0;
        load(1, 4, 8'h31, 8'h32, 8'h33, 8'h34, 1'b1);
        drive();
        tick();
        check("bp_grant", b4.grant_o, 4'b0010);
        tick();
        tick();
        check("bp_hold_entry", b4.tx_data_o, 8'h32);
        b4.tx_ready_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_data_stable", b4.tx_data_o, 8'h32);
            check("bp_valid_held", b4.tx_valid_o, 1);
            check("bp_ready1_low", b4.req_ready_o[1], 0);
            check("bp_stall_cnt", dut4.cnt, 0);
        end
        b4.tx_ready_i = 1'b1;
        run_until_idle(30);
        check("bp_no_timeout", to4_seen, 0);
        check("bp_byte_count", q4.size(), 4);
        for (int k = 0; k < 4 && k < q4.size(); k++) check("bp_stream", q4[k], 8'h31 + 8'(k));

        // Timeout on the 8-cycle instance: req2 stalls, req3 pending
        use8 = 1'b1;
        load(2, 1, 8'h42, 8'h00, 8'h00, 8'h00, 1'b0);
        load(3, 1, 8'h77, 8'h00, 8'h00, 8'h00, 1'b1);
        drive();
        tick();
        check("to_grant2", b8.grant_o, 4'b0100);
        tick();
        check("to_first_byte", b8.tx_data_o, 8'h42);
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("to_pulse_timing", b8.timeout_o, (k == 8) ? 1 : 0);
        end
        check("to_grant_clear", b8.grant_o, 0);
        check("to_busy_clear", b8.busy_o, 0);
        check("to_rr_ptr", dut8.rr_ptr, 3);
        tick();
        check("to_grant3", b8.grant_o, 4'b1000);
        check("to_pulse_single", b8.timeout_o, 0);
        tick();
        check("to_req3_byte", b8.tx_data_o, 8'h77);
        run_until_idle(30);
        use8 = 1'b0;

        // Asynchronous reset mid-message
        do_reset();
        load(0, 3, 8'h01, 8'h02, 8'h03, 8'h00, 1'b1);
        drive();
        tick();
        tick();
        check("mid_valid_before_rst", b4.tx_valid_o, 1);
        rst_n = 1'b0;
        #1;
        check_zero_outputs();
        clear_reqs();
        tick();
        check_zero_outputs();
        rst_n = 1'b1;
        gprev = '0;
        load(2, 1, 8'h55, 8'h00, 8'h00, 8'h00, 1'b1);
        drive();
        tick();
        check("post_rst_grant2", b4.grant_o, 4'b0100);
        tick();
        check("post_rst_byte", b4.tx_data_o, 8'h55);
        run_until_idle(20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit: got expired expected finish");
        $fatal(1, "time limit");
    end
endmodule
